asyn_fifo_rd_stream: RTL and testbench

- Read-side consumer for the team's asynchronous FIFO. Runs entirely in the read clock domain.
- Drives the FIFO pop strobe from the FIFO empty flag and accepts the registered read data, which arrives one cycle after the pop.
- Re-presents words as a valid/ready stream with packet framing (m_last) and a delivered-word counter.
- A 3-entry prefetch buffer gives full 1-word/cycle throughput. No combinational path runs from m_ready to fifo_rinc.

---
 rtl/asyn_fifo_pkg.sv | 16 +
 rtl/rd_prefetch_buf.sv | 68 ++++++
 rtl/asyn_fifo_rd_stream.sv | 87 ++++++++
 tb/tb_asyn_fifo_rd_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/asyn_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream logic.
package asyn_fifo_pkg;

  localparam int RD_BUF_DEPTH = 3;

  typedef logic [1:0] occ_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int beat_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// Three-entry circular prefetch buffer: write at end of push cycle, head visible next cycle.
// No backpressure of its own; the caller guarantees it never pushes when full or pops when empty.
module rd_prefetch_buf
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output occ_t             occ,
  output logic [WIDTH-1:0] head_dat
);

  logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [RD_BUF_DEPTH];
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       rd_idx_q, rd_idx_d;
  occ_t             occ_q, occ_d;

  function automatic logic [1:0] idx_inc(input logic [1:0] i);
    return (i == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_idx_d = 2'd0;
      rd_idx_d = 2'd0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_idx_q] = push_dat;
        wr_idx_d        = idx_inc(wr_idx_q);
      end
      if (pop) begin
        rd_idx_d = idx_inc(rd_idx_q);
      end
      occ_d = occ_q + occ_t'(push) - occ_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_idx_q <= 2'd0;
      rd_idx_q <= 2'd0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      occ_q    <= occ_d;
    end
  end

  assign occ      = occ_q;
  assign head_dat = mem_q[rd_idx_q];

endmodule

// File: rtl/asyn_fifo_rd_stream.sv
// Async-FIFO read side re-presented as a framed valid/ready stream; pop to m_valid is 2 cycles.
// Pops stop once buffered plus in-flight words reach 3; m_ready never reaches fifo_rinc.
module asyn_fifo_rd_stream
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             fifo_rempty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rinc,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] rd_count
);

  localparam int             BW        = beat_w(PKT_LEN);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_LEN - 1);

  logic             run_q, run_d;
  logic             infl_q, infl_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  occ_t             occ;
  logic [WIDTH-1:0] head;
  logic             push;
  logic             xfer;

  // run_q keeps the pop strobe low while reset is held, from registered state only.
  assign fifo_rinc = run_q && !fifo_rempty && !flush &&
                     (({1'b0, occ} + {2'b00, infl_q}) <= 3'd2);

  assign push     = infl_q && !flush;
  assign xfer     = m_valid && m_ready && !flush;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = head;
  assign m_last   = m_valid && (beat_q == LAST_BEAT);
  assign rd_count = cnt_q;

  always_comb begin
    run_d  = 1'b1;
    infl_d = fifo_rinc;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (flush) begin
      beat_d = '0;
    end else if (xfer) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      run_q  <= 1'b0;
      infl_q <= 1'b0;
      beat_q <= '0;
      cnt_q  <= '0;
    end else begin
      run_q  <= run_d;
      infl_q <= infl_d;
      beat_q <= beat_d;
      cnt_q  <= cnt_d;
    end
  end

  rd_prefetch_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .push     (push),
    .push_dat (fifo_rdata),
    .pop      (xfer),
    .clear    (flush),
    .occ      (occ),
    .head_dat (head)
  );

endmodule

// File: tb/tb_asyn_fifo_rd_stream.sv
// Bench: queue-based FIFO model feeds the DUT; a negedge monitor scores the stream.
module tb_asyn_fifo_rd_stream;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 4;
  localparam int CNT_W   = 16;

  logic             rclk;
  logic             rrst;
  logic             fifo_rempty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rinc;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] rd_count;

  asyn_fifo_rd_stream #(
    .WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)
  ) dut (
    .rclk(rclk), .rrst(rrst), .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata),
    .fifo_rinc(fifo_rinc), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .rd_count(rd_count)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] fq[$];     // contents of the upstream FIFO
  logic [WIDTH-1:0] exp_q[$];  // words popped from the FIFO and still owed downstream
  longint           exp_cnt = 0;
  int               exp_k   = 0;

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Stimulus changes land 2 time units after the rising edge.
  task automatic tick();
    @(posedge rclk);
    #2;
  endtask

  // Upstream FIFO: a pop requested in one cycle presents its word in the next.
  logic pop_pend;
  always begin
    @(negedge rclk);
    pop_pend = fifo_rinc && !rrst;
    @(posedge rclk);
    #1;
    if (pop_pend) begin
      if (fq.size() == 0) begin
        check("fifo_underflow", 1, 0);
      end else begin
        fifo_rdata = fq.pop_front();
        exp_q.push_back(fifo_rdata);
      end
    end
    #2;
    fifo_rempty = (fq.size() == 0);
  end

  // Monitor / scoreboard.
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;
  always @(negedge rclk) begin
    if (rrst) begin
      exp_q.delete();
      exp_cnt = 0;
      exp_k   = 0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_d);
      end
      if (fifo_rempty) check("rinc_while_empty", fifo_rinc, 0);
      check("held_le_3", exp_q.size() <= 3, 1);
      if (flush) begin
        check("rinc_during_flush", fifo_rinc, 0);
        exp_q.delete();
        exp_k = 0;
      end else if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", m_data, -1);
        end else begin
          check("data", m_data, exp_q.pop_front());
          check("last", m_last, (exp_k == PKT_LEN - 1) ? 1 : 0);
          check("rd_count", rd_count, exp_cnt % (64'd1 << CNT_W));
          exp_cnt++;
          exp_k = (exp_k + 1) % PKT_LEN;
        end
      end else if (!m_valid) begin
        check("last_unqualified", m_last, 0);
      end
      hold_v = m_valid && !m_ready && !flush;
      hold_d = m_data;
    end
  end

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || m_valid) && t < 200) begin
      tick();
      t++;
    end
    check(name, fq.size() + exp_q.size(), 0);
  endtask

  initial begin
    int first_r, first_v, last_v, nv;
    rrst        = 1'b1;
    flush       = 1'b0;
    m_ready     = 1'b1;
    fifo_rdata  = '0;
    fifo_rempty = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));

    // Reset held with a non-empty FIFO.
    repeat (3) tick();
    @(negedge rclk);
    check("rst_rinc", fifo_rinc, 0);
    check("rst_valid", m_valid, 0);
    check("rst_count", rd_count, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    tick();
    rrst = 1'b0;

    // Latency and full throughput.
    first_r = -1; first_v = -1; last_v = -1; nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (i == 1) check("rinc_after_release", fifo_rinc, 1);
      if (fifo_rinc && first_r < 0) first_r = i;
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
    end
    check("latency", first_v - first_r, 2);
    check("words", nv, 8);
    check("no_bubbles", last_v - first_v, 7);
    check("count_8", rd_count, 8);

    // Backpressure.
    tick();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h10 + i));
    repeat (10) tick();
    @(negedge rclk);
    check("bp_pops", 8 - fq.size(), 3);
    check("bp_rinc", fifo_rinc, 0);
    check("bp_valid", m_valid, 1);
    check("bp_data", m_data, 8'h10);
    tick();
    m_ready = 1'b1;
    drain("bp_drain");
    check("count_16", rd_count, 16);

    // FIFO runs dry between two pairs of words.
    fq.push_back(8'h30); fq.push_back(8'h31);
    repeat (8) tick();
    fq.push_back(8'h32); fq.push_back(8'h33);
    drain("refill_drain");
    check("count_20", rd_count, 20);

    // Flush with a full buffer and nothing in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h40 + i));
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge rclk);
    check("flush_valid", m_valid, 0);
    check("flush_count", rd_count, 20);
    tick();
    m_ready = 1'b1;
    drain("flush_drain");
    check("count_25", rd_count, 25);

    // Flush while streaming, with a word in flight and a transfer on the flush cycle.
    for (int i = 0; i < 10; i++) fq.push_back(8'(8'h60 + i));
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge rclk);
    check("flush_infl_valid", m_valid, 0);
    drain("flush_infl_drain");

    // Randomized traffic, backpressure and flushes.
    for (int i = 0; i < 600; i++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) != 0) fq.push_back(8'($urandom));
    end
    tick();
    flush   = 1'b0;
    m_ready = 1'b1;
    drain("rand_drain");

    // Reset in the middle of a stream; the FIFO resets alongside.
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h80 + i));
    repeat (4) tick();
    rrst = 1'b1;
    fq.delete();
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_count", rd_count, 0);
    check("midrst_rinc", fifo_rinc, 0);
    tick();
    rrst = 1'b0;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h90 + i));
    drain("midrst_drain");
    check("midrst_count4", rd_count, 4);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
